vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/vga_sync_delay.sv | 33 +++
 rtl/vga_timing_gen.sv | 126 ++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// VGA timing constants, derived totals and shared types.
// Used by vga_timing_gen and vga_sync_delay.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

    function automatic int line_total(int act, int fp, int syn, int bp);
        return act + fp + syn + bp;
    endfunction

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF =
        line_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL_DEF =
        line_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_sync_delay.sv
// Fixed-depth shift register with a reset value per stage.
// DEPTH=0 degenerates to a combinational pass-through.
module vga_sync_delay #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             vga_clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = vga_clk ^ reset;
        assign q = d;
    end else begin : g_sr
        logic [WIDTH-1:0] sr [DEPTH];

        always_ff @(posedge vga_clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
            end else begin
                sr[0] <= d;
                for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
            end
        end

        assign q = sr[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters, sync/blank generation and frame counter.
// Optional colour-bar generator: define VGA_TIMING_TEST_PATTERN_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int SYNC_DLY = 1
) (
    input  logic        vga_clk,
    input  logic        reset,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic        sync,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
`ifdef VGA_TIMING_TEST_PATTERN_EN
    ,
    output logic [3:0]  tp_red,
    output logic [3:0]  tp_green,
    output logic [3:0]  tp_blue
`endif
);

    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS  = coord_t'(H_ACTIVE);
    localparam coord_t V_VIS  = coord_t'(V_ACTIVE);
    localparam coord_t HS_BEG = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_BEG = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    coord_t hc;
    coord_t vc;
    logic   h_end;
    logic   v_end;

    assign h_end = (hc == H_LAST);
    assign v_end = (vc == V_LAST);

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hc          <= '0;
            vc          <= '0;
            frame_count <= '0;
        end else if (h_end) begin
            hc <= '0;
            vc <= v_end ? '0 : vc + 1'b1;
            if (v_end) frame_count <= frame_count + 16'd1;
        end else begin
            hc <= hc + 1'b1;
        end
    end

    assign DrawX       = hc;
    assign DrawY       = vc;
    assign sync        = 1'b0;
    assign line_start  = (hc == '0);
    assign frame_start = (hc == '0) && (vc == '0);

    sync_t s_u;
    sync_t s_d;

    // Blank is gated so a zero-depth delay still shows idle in reset.
    always_comb begin
        s_u       = SYNC_IDLE;
        s_u.hs    = !((hc >= HS_BEG) && (hc < HS_END));
        s_u.vs    = !((vc >= VS_BEG) && (vc < VS_END));
        s_u.blank = (hc < H_VIS) && (vc < V_VIS) && !reset;
    end

    vga_sync_delay #(
        .WIDTH   ($bits(sync_t)),
        .DEPTH   (SYNC_DLY),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_dly (
        .vga_clk (vga_clk),
        .reset   (reset),
        .d       (s_u),
        .q       (s_d)
    );

    assign hs    = s_d.hs;
    assign vs    = s_d.vs;
    assign blank = s_d.blank;

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam int     BAR_I = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam coord_t BAR_W = coord_t'(BAR_I);

    logic [2:0]  bar;
    logic [11:0] tp_u;
    logic [11:0] tp_d;

    assign bar  = 3'(hc / BAR_W);
    assign tp_u = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};

    vga_sync_delay #(
        .WIDTH   (12),
        .DEPTH   (SYNC_DLY),
        .RST_VAL ('0)
    ) u_tp_dly (
        .vga_clk (vga_clk),
        .reset   (reset),
        .d       (tp_u),
        .q       (tp_d)
    );

    assign {tp_red, tp_green, tp_blue} = s_d.blank ? tp_d : 12'h000;
`endif

endmodule
